// File: rtl/motor_mixer_if.sv
// Mixer-side bundle: PID rate commands and throttle in, four motor commands and status out.
// With MOTOR_MIXER_ARMING_EN defined the bundle also carries the 'armed' qualifier.
interface motor_mixer_if #(
  parameter int RATE_BIT_WIDTH  = 16,
  parameter int THROTTLE_WIDTH  = 16,
  parameter int MOTOR_BIT_WIDTH = 16
);
  logic        [THROTTLE_WIDTH-1:0]  throttle;
  logic signed [RATE_BIT_WIDTH-1:0]  roll_rate;
  logic signed [RATE_BIT_WIDTH-1:0]  pitch_rate;
  logic signed [RATE_BIT_WIDTH-1:0]  yaw_rate;
  logic                              start_flag;
`ifdef MOTOR_MIXER_ARMING_EN
  logic                              armed;
`endif
  logic        [MOTOR_BIT_WIDTH-1:0] motor_1;
  logic        [MOTOR_BIT_WIDTH-1:0] motor_2;
  logic        [MOTOR_BIT_WIDTH-1:0] motor_3;
  logic        [MOTOR_BIT_WIDTH-1:0] motor_4;
  logic                              mixer_active;
  logic                              mixer_complete;

  modport master (
`ifdef MOTOR_MIXER_ARMING_EN
    output armed,
`endif
    output throttle, roll_rate, pitch_rate, yaw_rate, start_flag,
    input  motor_1, motor_2, motor_3, motor_4, mixer_active, mixer_complete
  );

  modport slave (
`ifdef MOTOR_MIXER_ARMING_EN
    input  armed,
`endif
    input  throttle, roll_rate, pitch_rate, yaw_rate, start_flag,
    output motor_1, motor_2, motor_3, motor_4, mixer_active, mixer_complete
  );
endinterface

// File: rtl/motor_mixer.sv
// Quad-X motor mixer: throttle plus signed roll/pitch/yaw mixed over a 4-cycle registered datapath.
// Optional feature macro MOTOR_MIXER_ARMING_EN: when disarmed at LATCH, all motors are forced to MOTOR_MIN.
module motor_mixer #(
  parameter int                         RATE_BIT_WIDTH  = 16,
  parameter int                         THROTTLE_WIDTH  = 16,
  parameter int                         MOTOR_BIT_WIDTH = 16,
  parameter logic [MOTOR_BIT_WIDTH-1:0] MOTOR_MIN       = '0,
  parameter logic [MOTOR_BIT_WIDTH-1:0] MOTOR_MAX       = '1
) (
  input  logic          us_clk,
  input  logic          reset,
  motor_mixer_if.slave  mix
);

  localparam int ACC_W = ((THROTTLE_WIDTH > RATE_BIT_WIDTH) ? THROTTLE_WIDTH : RATE_BIT_WIDTH) + 3;

  localparam logic signed [ACC_W-1:0] MIN_S =
    $signed({{(ACC_W-MOTOR_BIT_WIDTH){1'b0}}, MOTOR_MIN});
  localparam logic signed [ACC_W-1:0] MAX_S =
    $signed({{(ACC_W-MOTOR_BIT_WIDTH){1'b0}}, MOTOR_MAX});

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    LATCH  = 6'b000010,
    MIX_RP = 6'b000100,
    MIX_Y  = 6'b001000,
    CLAMP  = 6'b010000,
    DONE   = 6'b100000
  } state_t;

  state_t state, state_nxt;

  logic        [THROTTLE_WIDTH-1:0]  thr_p0;
  logic signed [RATE_BIT_WIDTH-1:0]  roll_p0;
  logic signed [RATE_BIT_WIDTH-1:0]  pitch_p0;
  logic signed [RATE_BIT_WIDTH-1:0]  yaw_p0;
`ifdef MOTOR_MIXER_ARMING_EN
  logic                              armed_p0;
`endif
  logic signed [ACC_W-1:0]           acc_p1 [4];
  logic        [MOTOR_BIT_WIDTH-1:0] motor_p2 [4];

  function automatic logic signed [ACC_W-1:0] ext_thr(input logic [THROTTLE_WIDTH-1:0] t);
    return $signed({{(ACC_W-THROTTLE_WIDTH){1'b0}}, t});
  endfunction

  function automatic logic signed [ACC_W-1:0] ext_rate(input logic signed [RATE_BIT_WIDTH-1:0] r);
    return {{(ACC_W-RATE_BIT_WIDTH){r[RATE_BIT_WIDTH-1]}}, r};
  endfunction

  // Signed compare so a negative sum saturates low instead of wrapping to a large command.
  function automatic logic [MOTOR_BIT_WIDTH-1:0] sat_motor(input logic signed [ACC_W-1:0] a);
    if (a < MIN_S)      return MOTOR_MIN;
    else if (a > MAX_S) return MOTOR_MAX;
    else                return a[MOTOR_BIT_WIDTH-1:0];
  endfunction

  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    mix.mixer_active   = 1'b0;
    mix.mixer_complete = 1'b0;
    case (state)
      IDLE:   if (mix.start_flag) state_nxt = LATCH;
      LATCH:  begin state_nxt = MIX_RP; mix.mixer_active = 1'b1; end
      MIX_RP: begin state_nxt = MIX_Y;  mix.mixer_active = 1'b1; end
      MIX_Y:  begin state_nxt = CLAMP;  mix.mixer_active = 1'b1; end
      CLAMP:  begin state_nxt = DONE;   mix.mixer_active = 1'b1; end
      DONE: begin
        mix.mixer_complete = 1'b1;
        if (!mix.start_flag) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operand capture in LATCH only.
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      thr_p0   <= '0;
      roll_p0  <= '0;
      pitch_p0 <= '0;
      yaw_p0   <= '0;
`ifdef MOTOR_MIXER_ARMING_EN
      armed_p0 <= 1'b0;
`endif
    end else if (state == LATCH) begin
      thr_p0   <= mix.throttle;
      roll_p0  <= mix.roll_rate;
      pitch_p0 <= mix.pitch_rate;
      yaw_p0   <= mix.yaw_rate;
`ifdef MOTOR_MIXER_ARMING_EN
      armed_p0 <= mix.armed;
`endif
    end
  end

  // Stage p1: accumulate roll/pitch, then fold in yaw; headroom makes overflow impossible.
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) acc_p1[i] <= '0;
    end else if (state == MIX_RP) begin
      acc_p1[0] <= ext_thr(thr_p0) + ext_rate(pitch_p0) + ext_rate(roll_p0);
      acc_p1[1] <= ext_thr(thr_p0) + ext_rate(pitch_p0) - ext_rate(roll_p0);
      acc_p1[2] <= ext_thr(thr_p0) - ext_rate(pitch_p0) + ext_rate(roll_p0);
      acc_p1[3] <= ext_thr(thr_p0) - ext_rate(pitch_p0) - ext_rate(roll_p0);
    end else if (state == MIX_Y) begin
      acc_p1[0] <= acc_p1[0] - ext_rate(yaw_p0);
      acc_p1[1] <= acc_p1[1] + ext_rate(yaw_p0);
      acc_p1[2] <= acc_p1[2] + ext_rate(yaw_p0);
      acc_p1[3] <= acc_p1[3] - ext_rate(yaw_p0);
    end
  end

  // Stage p2: motor command registers, written only in CLAMP.
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) motor_p2[i] <= MOTOR_MIN;
    end else if (state == CLAMP) begin
      for (int i = 0; i < 4; i++) begin
`ifdef MOTOR_MIXER_ARMING_EN
        motor_p2[i] <= armed_p0 ? sat_motor(acc_p1[i]) : MOTOR_MIN;
`else
        motor_p2[i] <= sat_motor(acc_p1[i]);
`endif
      end
    end
  end

  assign mix.motor_1 = motor_p2[0];
  assign mix.motor_2 = motor_p2[1];
  assign mix.motor_3 = motor_p2[2];
  assign mix.motor_4 = motor_p2[3];

endmodule

// File: tb/tb_motor_mixer.sv
// Bench for motor_mixer: table vectors, handshake corner sequences and random mixes vs. a reference model.
`timescale 1ns/1ps
module tb_motor_mixer;

  localparam int MIN_I = 0;
  localparam int MAX_I = 65535;

  logic us_clk = 1'b0;
  logic reset  = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  motor_mixer_if #(.RATE_BIT_WIDTH(16), .THROTTLE_WIDTH(16), .MOTOR_BIT_WIDTH(16)) mif();

  motor_mixer #(
    .RATE_BIT_WIDTH(16), .THROTTLE_WIDTH(16), .MOTOR_BIT_WIDTH(16),
    .MOTOR_MIN(16'h0000), .MOTOR_MAX(16'hFFFF)
  ) dut (
    .us_clk(us_clk),
    .reset (reset),
    .mix   (mif)
  );

  always #500 us_clk = ~us_clk;

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct packed {
    logic [15:0] t, r, p, y;
    logic [15:0] e1, e2, e3, e4;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Reference: signed sum of the X-config terms, then saturate into the motor range.
  function automatic logic [15:0] ref_motor(input logic [15:0] t, input logic [15:0] r,
                                            input logic [15:0] p, input logic [15:0] y,
                                            input int sr, input int sp, input int sy);
    int v;
    v = int'(t) + sr * int'($signed(r)) + sp * int'($signed(p)) + sy * int'($signed(y));
    if (v < MIN_I) v = MIN_I;
    if (v > MAX_I) v = MAX_I;
    return 16'(v);
  endfunction

  task automatic drive(input logic [15:0] t, r, p, y, input logic arm);
    mif.throttle   = t;
    mif.roll_rate  = r;
    mif.pitch_rate = p;
    mif.yaw_rate   = y;
`ifdef MOTOR_MIXER_ARMING_EN
    mif.armed      = arm;
`else
    if (arm) begin end
`endif
  endtask

  // One full handshake; inputs are scrambled after LATCH to prove they are not re-sampled.
  task automatic mix_and_check(input string nm, input logic [15:0] t, r, p, y, input logic arm,
                               input logic [15:0] e1, e2, e3, e4, input int hold);
    logic [15:0] pm1;
    @(negedge us_clk);
    drive(t, r, p, y, arm);
    mif.start_flag = 1'b1;
    @(posedge us_clk);
    pm1 = mif.motor_1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge us_clk); #1;
      if (k == 1) drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
      if (k < 4) begin
        chk({nm, " active/complete mid-mix"}, {mif.mixer_active, mif.mixer_complete}, 2'b10);
        chk({nm, " motor_1 held mid-mix"}, mif.motor_1, pm1);
      end
    end
    chk({nm, " active/complete at E0+4"}, {mif.mixer_active, mif.mixer_complete}, 2'b01);
    chk({nm, " motor_1"}, mif.motor_1, e1);
    chk({nm, " motor_2"}, mif.motor_2, e2);
    chk({nm, " motor_3"}, mif.motor_3, e3);
    chk({nm, " motor_4"}, mif.motor_4, e4);
    for (int k = 0; k < hold; k++) begin
      @(posedge us_clk); #1;
      chk({nm, " hold: no restart"}, {mif.mixer_active, mif.mixer_complete}, 2'b01);
      chk({nm, " hold: motor_4 steady"}, mif.motor_4, e4);
    end
    @(negedge us_clk);
    mif.start_flag = 1'b0;
    @(posedge us_clk); #1;
    chk({nm, " back to idle"}, {mif.mixer_active, mif.mixer_complete}, 2'b00);
  endtask

  vec_t tbl [7];

  initial begin
    tbl[0] = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
    tbl[1] = '{16'h4000, 16'h0100, 16'h0000, 16'h0000, 16'h4100, 16'h3F00, 16'h4100, 16'h3F00};
    tbl[2] = '{16'hFF00, 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'hFEFF, 16'h0000, 16'hFF01};
    tbl[3] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0001};
    tbl[4] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[5] = '{16'h1000, 16'h0010, 16'h0200, 16'h0003, 16'h120D, 16'h11F3, 16'h0E13, 16'h0DED};
    tbl[6] = '{16'h0000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF};

    mif.start_flag = 1'b0;
    drive(16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
    repeat (2) @(negedge us_clk);
    chk("reset motor_1", mif.motor_1, 16'h0000);
    chk("reset motor_4", mif.motor_4, 16'h0000);
    chk("reset active/complete", {mif.mixer_active, mif.mixer_complete}, 2'b00);
    reset = 1'b0;
    repeat (2) @(negedge us_clk);
    chk("idle after reset", {mif.mixer_active, mif.mixer_complete}, 2'b00);

    for (int i = 0; i < 7; i++)
      mix_and_check($sformatf("vec%0d", i), tbl[i].t, tbl[i].r, tbl[i].p, tbl[i].y, 1'b1,
                    tbl[i].e1, tbl[i].e2, tbl[i].e3, tbl[i].e4, 0);

    // start_flag held through DONE, then dropped one cycle and re-raised for a fresh mix.
    mix_and_check("hold", 16'h3000, 16'h0000, 16'h0040, 16'h0000, 1'b1,
                  16'h3040, 16'h3040, 16'h2FC0, 16'h2FC0, 5);
    mix_and_check("re-raise", 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b1,
                  16'h1234, 16'h1234, 16'h1234, 16'h1234, 0);

    // Reset while in MIX_Y aborts the mix immediately.
    @(negedge us_clk);
    drive(16'h2000, 16'h0100, 16'h0000, 16'h0000, 1'b1);
    mif.start_flag = 1'b1;
    repeat (3) @(posedge us_clk);
    #1;
    chk("pre-reset active", mif.mixer_active, 1'b1);
    reset = 1'b1;
    #1;
    chk("midmix reset motor_1", mif.motor_1, 16'h0000);
    chk("midmix reset motor_3", mif.motor_3, 16'h0000);
    chk("midmix reset active/complete", {mif.mixer_active, mif.mixer_complete}, 2'b00);
    mif.start_flag = 1'b0;
    @(negedge us_clk);
    reset = 1'b0;
    @(posedge us_clk); #1;
    chk("post-reset idle", {mif.mixer_active, mif.mixer_complete}, 2'b00);
    mix_and_check("restart", 16'h2000, 16'h0100, 16'h0000, 16'h0000, 1'b1,
                  16'h2100, 16'h1F00, 16'h2100, 16'h1F00, 0);

`ifdef MOTOR_MIXER_ARMING_EN
    mix_and_check("disarmed", 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b0,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
    mix_and_check("rearmed", 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b1,
                  16'h8000, 16'h8000, 16'h8000, 16'h8000, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [15:0] t, r, p, y;
      t = 16'($urandom);
      r = 16'($urandom);
      p = 16'($urandom);
      y = 16'($urandom);
      if (n % 4 == 0) begin
        r = 16'($signed(16'($urandom_range(0, 511))) - 16'sd256);
        p = 16'($signed(16'($urandom_range(0, 511))) - 16'sd256);
        y = 16'($signed(16'($urandom_range(0, 511))) - 16'sd256);
      end
      mix_and_check($sformatf("rand%0d", n), t, r, p, y, 1'b1,
                    ref_motor(t, r, p, y,  1,  1, -1),
                    ref_motor(t, r, p, y, -1,  1,  1),
                    ref_motor(t, r, p, y,  1, -1,  1),
                    ref_motor(t, r, p, y, -1, -1, -1), n % 10 == 3 ? 2 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
